// File: rtl/hc595_serializer_pkg.sv
// Shared constants and state encoding for the 74HC595 frame serializer.
// Also imported by the bench so that its chain model uses the same frame layout.
package hc595_serializer_pkg;

    localparam int unsigned SEG_W      = 8;
    localparam int unsigned SEL_W      = 6;
    localparam int unsigned FRAME_BITS = SEG_W + SEL_W;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2
    } state_e;

    // Frame word as it appears in the chain: segments in the upper byte.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [SEG_W-1:0] seg,
                                                         input logic [SEL_W-1:0] sel);
        return {seg, sel};
    endfunction

endpackage

// File: rtl/hc595_serializer_if.sv
// Display-side bundle: scanner pattern in, 74HC595 control lines out.
// The serializer uses master; the chain or bench uses slave.
interface hc595_serializer_if;
    import hc595_serializer_pkg::*;

    logic [SEG_W-1:0] seg;
    logic [SEL_W-1:0] sel;
    logic             shcp;
    logic             stcp;
    logic             ds;
    logic             oe;

    modport master (
        input  seg,
        input  sel,
        output shcp,
        output stcp,
        output ds,
        output oe
    );

    modport slave (
        output seg,
        output sel,
        input  shcp,
        input  stcp,
        input  ds,
        input  oe
    );

endinterface

// File: rtl/hc595_serializer.sv
// Continuously shifts {seg, sel} MSB-first into a 74HC595 chain and latches it.
// Every output is a register; oe stays high until the first complete frame is latched.
module hc595_serializer
    import hc595_serializer_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    hc595_serializer_if.master  bus
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(DIV / 2);
    localparam logic [3:0]    BIT_LAST   = 4'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  shcp_q, shcp_d;
    logic                  stcp_q, stcp_d;
    logic                  ds_q, ds_d;
    logic                  oe_q, oe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            phase_q   <= '0;
            bit_idx_q <= '0;
            sr_q      <= '0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            ds_q      <= 1'b0;
            oe_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            sr_q      <= sr_d;
            shcp_q    <= shcp_d;
            stcp_q    <= stcp_d;
            ds_q      <= ds_d;
            oe_q      <= oe_d;
        end
    end

    // Outputs are derived from the next phase so each register mirrors the
    // phase it is entering; ds then changes exactly on shcp falling edges.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        sr_d      = sr_q;
        shcp_d    = shcp_q;
        stcp_d    = stcp_q;
        ds_d      = ds_q;
        oe_d      = oe_q;

        unique case (state_q)
            StLoad: begin
                sr_d      = frame_word(bus.seg, bus.sel);
                ds_d      = sr_d[FRAME_BITS-1];
                bit_idx_d = '0;
                phase_d   = '0;
                shcp_d    = 1'b0;
                stcp_d    = 1'b0;
                state_d   = StShift;
            end
            StShift: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    shcp_d  = 1'b0;
                    if (bit_idx_q == BIT_LAST) begin
                        stcp_d  = 1'b1;
                        state_d = StLatch;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        sr_d      = sr_q << 1;
                        ds_d      = sr_d[FRAME_BITS-1];
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                    shcp_d  = (phase_d >= PHASE_HALF);
                end
            end
            StLatch: begin
                shcp_d = 1'b0;
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    stcp_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = StLoad;
                end else begin
                    phase_d = phase_q + PW'(1);
                    stcp_d  = (phase_d < PHASE_HALF);
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign bus.shcp = shcp_q;
    assign bus.stcp = stcp_q;
    assign bus.ds   = ds_q;
    assign bus.oe   = oe_q;

endmodule
